// File: rtl/board_move_if.sv
// board_move_if: control/status bundle between the game FSM, the buttons and board_move_ctrl
// Ports (slave = board_move_ctrl side):
//   in  clear, enable, turn, next_btn, sel_btn, timeout
//   out x_plane[8:0], o_plane[8:0], cursor[3:0], move_valid, move_reject,
//       move_cell[3:0], winner[1:0], game_over
interface board_move_if;
  logic       clear;
  logic       enable;
  logic       turn;
  logic       next_btn;
  logic       sel_btn;
  logic       timeout;
  logic [8:0] x_plane;
  logic [8:0] o_plane;
  logic [3:0] cursor;
  logic       move_valid;
  logic       move_reject;
  logic [3:0] move_cell;
  logic [1:0] winner;
  logic       game_over;
  modport master (
    output clear, enable, turn, next_btn, sel_btn, timeout,
    input  x_plane, o_plane, cursor, move_valid, move_reject, move_cell, winner, game_over
  );
  modport slave (
    input  clear, enable, turn, next_btn, sel_btn, timeout,
    output x_plane, o_plane, cursor, move_valid, move_reject, move_cell, winner, game_over
  );
endinterface

// File: rtl/board_move_ctrl.sv
// board_move_ctrl: tic-tac-toe move entry -- cursor seek, mark placement, win/draw detection
// Ports: clk, rst (async, active-high), bus (board_move_if.slave: button/enable inputs,
//   occupancy planes, cursor, move pulses, winner/game_over outputs).
// Optional build macro AUTO_MOVE_EN: a timeout edge auto-places on the lowest free cell.
module board_move_ctrl #(
  parameter logic [3:0] CURSOR_INIT = 4'd4
) (
  input logic         clk,
  input logic         rst,
  board_move_if.slave bus
);
  typedef enum logic [2:0] {IDLE, SEEK, PLACE, CHECK, OVER} state_t;
  state_t     state_q, state_d;
  logic [2:0] prev_q, prev_d;
  logic [8:0] x_plane_q, x_plane_d, o_plane_q, o_plane_d;
  logic [3:0] cursor_q, cursor_d, step_q, step_d, move_cell_q, move_cell_d;
  logic       move_valid_q, move_valid_d, move_reject_q, move_reject_d;
  logic [1:0] winner_q, winner_d;
  logic       sel_e, next_e, tmo_e;
  logic [8:0] occ;
  logic [3:0] cursor_inc;
  function automatic logic line_win(input logic [8:0] p);
    return (&p[2:0]) | (&p[5:3]) | (&p[8:6]) |
           (p[0] & p[3] & p[6]) | (p[1] & p[4] & p[7]) | (p[2] & p[5] & p[8]) |
           (p[0] & p[4] & p[8]) | (p[2] & p[4] & p[6]);
  endfunction
  // prev regs reset high so a button held through reset yields no edge
  assign next_e     = bus.next_btn & ~prev_q[0];
  assign sel_e      = bus.sel_btn  & ~prev_q[1];
  assign tmo_e      = bus.timeout  & ~prev_q[2];
  assign occ        = x_plane_q | o_plane_q;
  assign cursor_inc = (cursor_q == 4'd8) ? 4'd0 : cursor_q + 4'd1;
`ifdef AUTO_MOVE_EN
  logic [3:0] first_free;
  always_comb begin
    first_free = 4'd0;
    for (int i = 8; i >= 0; i--) first_free = occ[i] ? first_free : 4'(i);
  end
`else
  logic unused_tmo;
  assign unused_tmo = tmo_e;
`endif
  always_comb begin
    state_d       = state_q;
    prev_d        = {bus.timeout, bus.sel_btn, bus.next_btn};
    x_plane_d     = x_plane_q;
    o_plane_d     = o_plane_q;
    cursor_d      = cursor_q;
    step_d        = step_q;
    move_cell_d   = move_cell_q;
    move_valid_d  = 1'b0;
    move_reject_d = 1'b0;
    winner_d      = winner_q;
    case (state_q)
      IDLE: if (bus.enable) begin
        if (sel_e) begin
          move_reject_d = occ[cursor_q];
          state_d       = occ[cursor_q] ? IDLE : PLACE;
        end
`ifdef AUTO_MOVE_EN
        else if (tmo_e && !(&occ)) begin
          cursor_d = first_free;
          state_d  = PLACE;
        end
`endif
        else if (next_e) begin
          step_d  = 4'd0;
          state_d = SEEK;
        end
      end
      // step_q == 8 marks the ninth move: a full sweep returns to the start cell
      SEEK: begin
        cursor_d = cursor_inc;
        step_d   = step_q + 4'd1;
        state_d  = (!occ[cursor_inc] || step_q == 4'd8) ? IDLE : SEEK;
      end
      PLACE: begin
        x_plane_d    = bus.turn ? x_plane_q : x_plane_q | (9'd1 << cursor_q);
        o_plane_d    = bus.turn ? o_plane_q | (9'd1 << cursor_q) : o_plane_q;
        move_valid_d = 1'b1;
        move_cell_d  = cursor_q;
        state_d      = CHECK;
      end
      CHECK: begin
        winner_d = line_win(x_plane_q) ? 2'b01 :
                   line_win(o_plane_q) ? 2'b10 :
                   (&occ)              ? 2'b11 : 2'b00;
        state_d  = (winner_d != 2'b00) ? OVER : IDLE;
      end
      default: ;
    endcase
    if (bus.clear) begin
      state_d       = IDLE;
      x_plane_d     = 9'd0;
      o_plane_d     = 9'd0;
      cursor_d      = CURSOR_INIT;
      step_d        = 4'd0;
      move_cell_d   = 4'd0;
      move_valid_d  = 1'b0;
      move_reject_d = 1'b0;
      winner_d      = 2'b00;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      prev_q        <= 3'b111;
      x_plane_q     <= 9'd0;
      o_plane_q     <= 9'd0;
      cursor_q      <= CURSOR_INIT;
      step_q        <= 4'd0;
      move_cell_q   <= 4'd0;
      move_valid_q  <= 1'b0;
      move_reject_q <= 1'b0;
      winner_q      <= 2'b00;
    end else begin
      state_q       <= state_d;
      prev_q        <= prev_d;
      x_plane_q     <= x_plane_d;
      o_plane_q     <= o_plane_d;
      cursor_q      <= cursor_d;
      step_q        <= step_d;
      move_cell_q   <= move_cell_d;
      move_valid_q  <= move_valid_d;
      move_reject_q <= move_reject_d;
      winner_q      <= winner_d;
    end
  end
  assign bus.x_plane     = x_plane_q;
  assign bus.o_plane     = o_plane_q;
  assign bus.cursor      = cursor_q;
  assign bus.move_valid  = move_valid_q;
  assign bus.move_reject = move_reject_q;
  assign bus.move_cell   = move_cell_q;
  assign bus.winner      = winner_q;
  assign bus.game_over   = |winner_q;
endmodule

// File: tb/tb_board_move_ctrl.sv
// tb_board_move_ctrl: self-checking bench for board_move_ctrl (board-level model, per-cycle compare)
module tb_board_move_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  board_move_if bus();
  board_move_ctrl #(.CURSOR_INIT(4'd4)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  int lines [8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6}, '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};
  logic [8:0] m_x, m_o;
  logic [3:0] m_cur, m_cell;
  logic [1:0] m_win;
  logic       m_valid, m_rej;
  int passes = 0;
  int fails  = 0;
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    if (got === exp) passes++;
    else begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask
  function automatic bit has_line(input logic [8:0] p);
    for (int l = 0; l < 8; l++)
      if (p[lines[l][0]] && p[lines[l][1]] && p[lines[l][2]]) return 1'b1;
    return 1'b0;
  endfunction
  function automatic bit is_free(input logic [3:0] c);
    return ((m_x | m_o) & (9'd1 << c)) == 9'd0;
  endfunction
  function automatic bit live();
    return bus.enable && m_win == 2'b00;
  endfunction
  always @(negedge clk) begin
    chk("x_plane", 32'(bus.x_plane), 32'(m_x));
    chk("o_plane", 32'(bus.o_plane), 32'(m_o));
    chk("cursor", 32'(bus.cursor), 32'(m_cur));
    chk("move_valid", 32'(bus.move_valid), 32'(m_valid));
    chk("move_reject", 32'(bus.move_reject), 32'(m_rej));
    chk("move_cell", 32'(bus.move_cell), 32'(m_cell));
    chk("winner", 32'(bus.winner), 32'(m_win));
    chk("game_over", 32'(bus.game_over), 32'(m_win != 2'b00));
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  // called just after the accepting edge: mark one cycle later, result one more cycle later
  task automatic place_seq();
    tick();
    if (bus.turn) m_o = m_o | (9'd1 << m_cur);
    else m_x = m_x | (9'd1 << m_cur);
    m_valid = 1'b1;
    m_cell  = m_cur;
    tick();
    m_valid = 1'b0;
    m_win   = has_line(m_x) ? 2'b01 : has_line(m_o) ? 2'b10 : (&(m_x | m_o)) ? 2'b11 : 2'b00;
  endtask
  task automatic press_sel();
    bus.sel_btn = 1'b1;
    tick();
    bus.sel_btn = 1'b0;
    if (!live()) begin
      tick();
      tick();
    end else if (!is_free(m_cur)) begin
      m_rej = 1'b1;
      tick();
      m_rej = 1'b0;
      tick();
    end else place_seq();
    tick();
  endtask
  task automatic press_next();
    bus.next_btn = 1'b1;
    tick();
    bus.next_btn = 1'b0;
    if (!live()) begin
      tick();
      tick();
    end else
      for (int i = 0; i < 9; i++) begin
        tick();
        m_cur = (m_cur == 4'd8) ? 4'd0 : m_cur + 4'd1;
        if (is_free(m_cur)) break;
      end
    tick();
  endtask
  task automatic press_timeout();
    bus.timeout = 1'b1;
    tick();
    bus.timeout = 1'b0;
`ifdef AUTO_MOVE_EN
    if (live() && !(&(m_x | m_o))) begin
      for (int i = 8; i >= 0; i--) if (is_free(4'(i))) m_cur = 4'(i);
      place_seq();
    end else begin
      tick();
      tick();
    end
`else
    tick();
    tick();
`endif
    tick();
  endtask
  task automatic do_clear(input logic with_sel);
    bus.clear   = 1'b1;
    bus.sel_btn = with_sel;
    tick();
    bus.clear   = 1'b0;
    bus.sel_btn = 1'b0;
    m_x = 9'd0; m_o = 9'd0; m_cur = 4'd4; m_cell = 4'd0; m_win = 2'b00; m_valid = 1'b0; m_rej = 1'b0;
    tick();
    tick();
  endtask
  task automatic place_at(input logic t);
    bus.turn = t;
    press_sel();
  endtask
  initial begin
    bus.clear = 1'b0; bus.enable = 1'b1; bus.turn = 1'b0;
    bus.next_btn = 1'b0; bus.sel_btn = 1'b1; bus.timeout = 1'b0;
    m_x = 9'd0; m_o = 9'd0; m_cur = 4'd4; m_cell = 4'd0; m_win = 2'b00; m_valid = 1'b0; m_rej = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick(); tick(); tick();
    chk("rst_cursor", 32'(bus.cursor), 32'd4);
    chk("rst_planes", 32'({bus.x_plane, bus.o_plane}), 32'd0);
    chk("rst_winner", 32'(bus.winner), 32'd0);
    bus.sel_btn = 1'b0;
    tick();
    place_at(1'b0);
    chk("first_x", 32'(bus.x_plane), 32'h010);
    place_at(1'b0);
    chk("reject_x", 32'(bus.x_plane), 32'h010);
    chk("reject_o", 32'(bus.o_plane), 32'h000);
    bus.enable = 1'b0;
    press_sel();
    press_next();
    chk("disabled_cursor", 32'(bus.cursor), 32'd4);
    bus.enable = 1'b1;
    do_clear(1'b0);
    place_at(1'b1); press_next();
    place_at(1'b1); press_next();
    place_at(1'b1); press_next();
    place_at(1'b0); press_next();
    place_at(1'b0); press_next();
    place_at(1'b0); press_next();
    place_at(1'b0); press_next();
    chk("win_cursor", 32'(bus.cursor), 32'd2);
    place_at(1'b0);
    chk("win_x", 32'(bus.x_plane), 32'h187);
    chk("win_o", 32'(bus.o_plane), 32'h070);
    chk("win_winner", 32'(bus.winner), 32'd1);
    chk("win_over", 32'(bus.game_over), 32'd1);
    place_at(1'b1);
    press_next();
    chk("over_cursor", 32'(bus.cursor), 32'd2);
    chk("over_o", 32'(bus.o_plane), 32'h070);
    do_clear(1'b1);
    chk("clr_winner", 32'(bus.winner), 32'd0);
    chk("clr_planes", 32'({bus.x_plane, bus.o_plane}), 32'd0);
    chk("clr_valid", 32'(bus.move_valid), 32'd0);
    place_at(1'b1); press_next();
    place_at(1'b1); press_next();
    place_at(1'b1); press_next();
    place_at(1'b0); press_next();
    place_at(1'b0); press_next();
    place_at(1'b0); press_next();
    place_at(1'b1); press_next();
    place_at(1'b0); press_next();
    chk("draw_cursor", 32'(bus.cursor), 32'd3);
    place_at(1'b0);
    chk("draw_x", 32'(bus.x_plane), 32'h18D);
    chk("draw_o", 32'(bus.o_plane), 32'h072);
    chk("draw_winner", 32'(bus.winner), 32'd3);
    do_clear(1'b0);
    bus.turn = 1'b0; press_timeout();
    bus.turn = 1'b1; press_timeout();
    bus.turn = 1'b0; press_timeout();
    bus.turn = 1'b1; press_timeout();
`ifdef AUTO_MOVE_EN
    chk("auto_o", 32'(bus.o_plane), 32'h00A);
    chk("auto_x", 32'(bus.x_plane), 32'h005);
    chk("auto_cell", 32'(bus.move_cell), 32'd3);
`else
    chk("tmo_planes", 32'({bus.x_plane, bus.o_plane}), 32'd0);
    chk("tmo_cursor", 32'(bus.cursor), 32'd4);
    chk("tmo_cell", 32'(bus.move_cell), 32'd0);
`endif
    tick();
    $display("%0d/%0d checks passed", passes, passes + fails);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: run did not reach its end, expected completion");
    $fatal(1);
  end
endmodule

// File: doc/board_move_ctrl.md
# board_move_ctrl

Move-entry stage for the tic-tac-toe game, sitting directly upstream of the board register and `videoGen`. It turns debounced player buttons into cursor movement and mark placement on two 9-bit occupancy planes (X and O). It rejects moves on occupied cells, evaluates win and draw after every move, and reports the result to the game FSM. Cell index n maps to row n/3, column n%3.

## Interface
- `CURSOR_INIT`, default 4: cursor cell after reset or clear (0..8).
- `clk`  in  1  system clock, the same clock as the FSM and timer.
- `rst`  in  1  reset; asynchronous, active-high.
- `clear`  in  1  synchronous new-game clear; level-sensitive.
- `enable`  in  1  moves accepted only while high (FSM play states).
- `turn`  in  1  0 = player 1 (X), 1 = player 2 (O); sampled in PLACE.
- `next_btn`  in  1  debounced level; rising edge advances the cursor.
- `sel_btn`  in  1  debounced level; rising edge places a mark.
- `timeout`  in  1  turn-timer `done`; rising edge significant.
- `x_plane`  out  9  X occupancy, bit n = cell n.
- `o_plane`  out  9  O occupancy.
- `cursor`  out  4  current cursor cell, 0..8.
- `move_valid`  out  1  one-cycle pulse when a mark is written.
- `move_reject`  out  1  one-cycle pulse when a select hits an occupied cell.
- `move_cell`  out  4  cell written; holds its value until the next write.
- `winner`  out  2  00 none, 01 X, 10 O, 11 draw.
- `game_over`  out  1  high while `winner != 00`.

## Operation
- Edge detect: a per-input prev register, reset to 1. `edge = in & ~prev`. An input held high through reset produces no edge.
- States: IDLE, SEEK, PLACE, CHECK, OVER.
- IDLE, `enable` high, one edge per cycle, priority sel > timeout > next:
  - sel edge: free cursor cell -> PLACE; occupied -> `move_reject` pulse, stay in IDLE.
  - next edge -> SEEK with step counter = 0.
  - timeout edge: see Configuration.
- Edges arriving while `enable` is low or outside IDLE are discarded, not queued.
- SEEK: each cycle `cursor <= (cursor==8) ? 0 : cursor+1` and `step <= step+1`. Return to IDLE when the new cell is free or step reaches 8, which is 9 moves. A full sweep lands back on the start cell. `enable` falling does not abort SEEK.
- PLACE: set bit `cursor` in `x_plane` if `turn`=0, else in `o_plane`. Pulse `move_valid`, load `move_cell <= cursor`, go to CHECK.
- CHECK: evaluate the 8 lines (3 rows, 3 cols, 2 diagonals) on the updated planes and register `winner`.
  - X win -> 01. O win -> 10. If both, X has priority (unreachable in legal play).
  - All 9 cells occupied and no win -> 11.
  - Nonzero winner -> OVER, else IDLE.
- OVER: all edges ignored; outputs hold.
- `clear` high in any state: next edge sets planes 0, cursor `CURSOR_INIT`, winner 00, `move_cell` 0, state IDLE. Clear overrides any simultaneous edge.

## Timing
- Reset values: planes 0, `cursor`=`CURSOR_INIT`, `move_valid`=0, `move_reject`=0, `move_cell`=0, `winner`=00, `game_over`=0, state IDLE.
- Select edge sampled at clock k (first rising edge where sel=1 and prev=0):
  - state PLACE after k;
  - plane bit and `move_valid` high after k+1;
  - `winner` and `game_over` valid after k+2.
- `move_reject` high for exactly the cycle after k.
- Next edge at k: first cursor step visible after k+1; worst case 9 cycles in SEEK.
- All outputs are registered; no combinational input-to-output path.

## Configuration
- `AUTO_MOVE_EN` defined: a timeout edge in IDLE with `enable` high sets `cursor` to the lowest-index free cell (priority encoder) and goes to PLACE. The mark is placed for `turn`, with the same latency as a select edge.
- Not defined: timeout edges are ignored; the FSM alone handles the turn pass. No priority encoder is built.

## Test plan
- Reset with `sel_btn` held high -> no `move_valid`; `cursor`=4, planes 0, `winner`=00.
- enable=1, turn=0, sel edge -> `x_plane`=9'h010 and `move_valid` one cycle later; second sel edge -> `move_reject` pulse, planes unchanged.
- X on cells 0,1; next edges to cell 2; sel with turn=0 -> `x_plane`=9'h007, `winner`=01 two cycles after the write, `game_over`=1; later sel edges ignored.
- Board with 8 cells filled (no line), cursor on the filled cell 3 (free cell 8), next edge -> cursor steps 4..8 and stops at 8 after 5 cycles. Sel -> full board, `winner`=11.
- `AUTO_MOVE_EN`, cells 0-2 occupied, timeout edge, turn=1 -> `o_plane` bit 3 set, `move_cell`=3. Without the macro -> no change.
- `clear` asserted in the same cycle as a sel edge in OVER -> planes 0, `winner`=00, state IDLE, no `move_valid`.
